// File: rtl/vga_tile_fill.sv
// ---------------------------------------------------------------------------
// vga_tile_fill
//
// Purpose:
//   Command-driven rectangle fill engine for the 20x15 tile framebuffer that
//   the VGA scan-out stage reads (one 32-bit word per 32x32-pixel block).
//   The processor issues one fill command. The engine then writes the 3-bit
//   BGR colour into every tile of the rectangle, one tile per cycle, in
//   row-major order.
//
// Build option:
//   TILE_CLIP_EN  defined   : rectangles that run off the grid are clipped
//                             to the grid edge.
//                 undefined : rectangles that run off the grid are rejected
//                             whole (done + err, no writes).
//
// Ports:
//   clock      in   single clock, all state updates on its rising edge
//   reset      in   asynchronous, active-high, clears all state
//   cmd_valid  in   a command is present
//   cmd_ready  out  engine can accept a command (IDLE, reset released)
//   cmd_x      in   start column            (5 bits)
//   cmd_y      in   start row               (4 bits)
//   cmd_w      in   width in tiles, 0=empty (5 bits)
//   cmd_h      in   height in tiles, 0=empty(4 bits)
//   cmd_color  in   colour {B,G,R}
//   wr_stall   in   memory port busy; the presented write is not taken
//   wr_en      out  write request (registered)
//   wr_addr    out  12-bit word address (registered)
//   wr_data    out  {zeros, colour} (registered)
//   busy       out  engine is not IDLE
//   done       out  one-cycle pulse when a command completes
//   err        out  one-cycle pulse alongside done for a rejected command
// ---------------------------------------------------------------------------
module vga_tile_fill #(
  parameter logic [11:0] BASE_ADDR = 12'hE00,
  parameter int          H_BLOCKS  = 20,
  parameter int          V_BLOCKS  = 15,
  parameter int          DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [4:0]        cmd_w,
  input  logic [3:0]        cmd_h,
  input  logic [2:0]        cmd_color,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [11:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Grid dimensions in the widths used by the datapath.
  localparam logic [5:0]  HB6  = 6'(H_BLOCKS);
  localparam logic [5:0]  VB6  = 6'(V_BLOCKS);
  localparam logic [11:0] HB12 = 12'(H_BLOCKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // State and registered outputs
  state_t              r_state;
  logic [4:0]          r_x;
  logic [4:0]          r_col;
  logic [3:0]          r_row;
  logic [5:0]          r_xEnd;
  logic [5:0]          r_yEnd;
  logic [11:0]         r_rowBase;
  logic                r_wrEn;
  logic [11:0]         r_wrAddr;
  logic [DATA_W-1:0]   r_wrData;
  logic                r_done;
  logic                r_err;

  // Next-state values
  state_t              w_stateNext;
  logic [4:0]          w_xNext;
  logic [4:0]          w_colNext;
  logic [3:0]          w_rowNext;
  logic [5:0]          w_xEndNext;
  logic [5:0]          w_yEndNext;
  logic [11:0]         w_rowBaseNext;
  logic                w_wrEnNext;
  logic [11:0]         w_wrAddrNext;
  logic [DATA_W-1:0]   w_wrDataNext;
  logic                w_doneNext;
  logic                w_errNext;

  // Command decode
  logic                w_accept;
  logic [5:0]          w_xSum;
  logic [5:0]          w_ySum;
  logic [5:0]          w_xEnd;
  logic [5:0]          w_yEnd;
  logic                w_empty;
  logic                w_reject;
  logic [11:0]         w_rowBase;
  logic [11:0]         w_firstAddr;
  logic [DATA_W-1:0]   w_colorWord;

  // Fill walk
  logic                w_taken;
  logic                w_lastCol;
  logic                w_lastRow;
  logic [11:0]         w_nextRowBase;

  // cmd_ready is held low while reset is asserted, even though the state
  // register already reads IDLE at that point.
  assign cmd_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  assign wr_en   = r_wrEn;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign done    = r_done;
  assign err     = r_err;

  // The sums are 6 bits wide: 31+31 and 15+15 both fit, so nothing wraps
  // before the clip against the grid edge.
  assign w_xSum = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign w_ySum = {2'b0, cmd_y} + {2'b0, cmd_h};
  assign w_xEnd = (w_xSum > HB6) ? HB6 : w_xSum;
  assign w_yEnd = (w_ySum > VB6) ? VB6 : w_ySum;

  // Zero width or height gives an empty area. So does a start beyond the
  // grid, because the clipped end then lies at or before the start.
  assign w_empty = (w_xEnd <= {1'b0, cmd_x}) || (w_yEnd <= {2'b0, cmd_y});

`ifdef TILE_CLIP_EN
  assign w_reject = 1'b0;
`else
  assign w_reject = (w_xSum > HB6) || (w_ySum > VB6);
`endif

  assign w_rowBase   = BASE_ADDR + (12'(cmd_y) * HB12);
  assign w_firstAddr = w_rowBase + 12'(cmd_x);
  assign w_colorWord = {{(DATA_W-3){1'b0}}, cmd_color};

  assign w_taken       = r_wrEn && !wr_stall;
  assign w_lastCol     = ({1'b0, r_col} == (r_xEnd - 6'd1));
  assign w_lastRow     = ({2'b0, r_row} == (r_yEnd - 6'd1));
  assign w_nextRowBase = r_rowBase + HB12;

  // Next-state and next-output logic. Every output is registered, so this
  // block also computes the value each output takes in the following cycle.
  // Pulses default to zero. Everything else defaults to holding its value.
  always_comb begin
    w_stateNext   = r_state;
    w_xNext       = r_x;
    w_colNext     = r_col;
    w_rowNext     = r_row;
    w_xEndNext    = r_xEnd;
    w_yEndNext    = r_yEnd;
    w_rowBaseNext = r_rowBase;
    w_wrEnNext    = r_wrEn;
    w_wrAddrNext  = r_wrAddr;
    w_wrDataNext  = r_wrData;
    w_doneNext    = 1'b0;
    w_errNext     = 1'b0;

    case (r_state)
      IDLE: begin
        w_wrEnNext = 1'b0;
        if (w_accept) begin
          w_xNext       = cmd_x;
          w_colNext     = cmd_x;
          w_rowNext     = cmd_y;
          w_xEndNext    = w_xEnd;
          w_yEndNext    = w_yEnd;
          w_rowBaseNext = w_rowBase;
          if (w_reject) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
            w_errNext   = 1'b1;
          end else if (w_empty) begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext  = FILL;
            w_wrEnNext   = 1'b1;
            w_wrAddrNext = w_firstAddr;
            w_wrDataNext = w_colorWord;
          end
        end
      end

      FILL: begin
        // On a stall the defaults hold the address and data unchanged.
        if (w_taken) begin
          if (w_lastCol) begin
            if (w_lastRow) begin
              w_stateNext = DONE;
              w_wrEnNext  = 1'b0;
              w_doneNext  = 1'b1;
            end else begin
              w_colNext     = r_x;
              w_rowNext     = r_row + 4'd1;
              w_rowBaseNext = w_nextRowBase;
              w_wrAddrNext  = w_nextRowBase + 12'(r_x);
            end
          end else begin
            w_colNext    = r_col + 5'd1;
            w_wrAddrNext = r_wrAddr + 12'd1;
          end
        end
      end

      DONE: begin
        w_stateNext = IDLE;
        w_wrEnNext  = 1'b0;
      end

      default: begin
        w_stateNext = IDLE;
        w_wrEnNext  = 1'b0;
      end
    endcase
  end

  // State and output registers. The reset is asynchronous, so wr_en drops
  // as soon as reset rises. Any command in progress is discarded without
  // a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_xEnd    <= '0;
      r_yEnd    <= '0;
      r_rowBase <= BASE_ADDR;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= BASE_ADDR;
      r_wrData  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_x       <= w_xNext;
      r_col     <= w_colNext;
      r_row     <= w_rowNext;
      r_xEnd    <= w_xEndNext;
      r_yEnd    <= w_yEndNext;
      r_rowBase <= w_rowBaseNext;
      r_wrEn    <= w_wrEnNext;
      r_wrAddr  <= w_wrAddrNext;
      r_wrData  <= w_wrDataNext;
      r_done    <= w_doneNext;
      r_err     <= w_errNext;
    end
  end

endmodule

// File: tb/tb_vga_tile_fill.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_fill
//
// Directed bench for vga_tile_fill. Each command pushes the writes it should
// produce onto a scoreboard queue. A monitor pops and compares an entry for
// every write the DUT actually gets taken. Handshake, done/err timing and
// reset behaviour are checked inline in the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_vga_tile_fill;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_x;
  logic [3:0]  cmd_y;
  logic [4:0]  cmd_w;
  logic [3:0]  cmd_h;
  logic [2:0]  cmd_color;
  logic        wr_stall;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int nVectors = 0;
  int nMiscompares = 0;

  // Each entry is {addr[11:0], data[31:0]}.
  logic [43:0] sbQ[$];
  logic [43:0] expWord;

  vga_tile_fill dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one command for a single cycle (the accept cycle T) and records
  // the writes it should produce. Returns at T+1, one time unit after the
  // clock edge.
  task automatic applyStimulus(input int x, input int y, input int w,
                               input int h, input int color);
    int xe;
    int ye;
    bit reject;
    logic [11:0] a;
    xe = (x + w > 20) ? 20 : x + w;
    ye = (y + h > 15) ? 15 : y + h;
`ifdef TILE_CLIP_EN
    reject = 1'b0;
`else
    reject = (x + w > 20) || (y + h > 15);
`endif
    if (!reject) begin
      for (int r = y; r < ye; r++) begin
        for (int c = x; c < xe; c++) begin
          a = 12'(12'hE00 + r * 20 + c);
          sbQ.push_back({a, 32'(color)});
        end
      end
    end
    checkOutput("cmd_ready_before_cmd", 48'(cmd_ready), 48'd1);
    cmd_x     = 5'(x);
    cmd_y     = 4'(y);
    cmd_w     = 5'(w);
    cmd_h     = 4'(h);
    cmd_color = 3'(color);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  // Scoreboard monitor. It compares every write the DUT gets taken, sampling
  // on the falling edge, away from the active clock edge.
  always @(negedge clock) begin
    if (!reset && wr_en === 1'b1 && wr_stall === 1'b0) begin
      checkOutput("write_expected", 48'(sbQ.size() != 0), 48'd1);
      if (sbQ.size() != 0) begin
        expWord = sbQ.pop_front();
        checkOutput("wr_addr", 48'(wr_addr), 48'(expWord[43:32]));
        checkOutput("wr_data", 48'(wr_data), 48'(expWord[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    wr_stall  = 1'b0;

    // Reset values
    step();
    step();
    checkOutput("rst_cmd_ready", 48'(cmd_ready), 48'd0);
    checkOutput("rst_wr_en",     48'(wr_en),     48'd0);
    checkOutput("rst_wr_addr",   48'(wr_addr),   48'hE00);
    checkOutput("rst_wr_data",   48'(wr_data),   48'd0);
    checkOutput("rst_busy",      48'(busy),      48'd0);
    checkOutput("rst_done",      48'(done),      48'd0);
    checkOutput("rst_err",       48'(err),       48'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 48'(cmd_ready), 48'd1);
    step();

    // Single-tile fill at (0,0), colour 3'b100
    $display("[TB] single tile");
    applyStimulus(0, 0, 1, 1, 4);
    checkOutput("t1_wr_en_T1",    48'(wr_en),     48'd1);
    checkOutput("t1_addr_T1",     48'(wr_addr),   48'hE00);
    checkOutput("t1_data_T1",     48'(wr_data),   48'h4);
    checkOutput("t1_busy_T1",     48'(busy),      48'd1);
    checkOutput("t1_ready_T1",    48'(cmd_ready), 48'd0);
    step();
    checkOutput("t1_done_T2",     48'(done),      48'd1);
    checkOutput("t1_err_T2",      48'(err),       48'd0);
    checkOutput("t1_wr_en_T2",    48'(wr_en),     48'd0);
    step();
    checkOutput("t1_done_T3",     48'(done),      48'd0);
    checkOutput("t1_ready_T3",    48'(cmd_ready), 48'd1);

    // Three-tile row with a two-cycle stall on the second write
    $display("[TB] stall");
    applyStimulus(2, 1, 3, 1, 2);
    checkOutput("t2_addr_T1", 48'(wr_addr), 48'hE16);
    step();
    wr_stall = 1'b1;
    checkOutput("t2_addr_T2", 48'(wr_addr), 48'hE17);
    step();
    checkOutput("t2_addr_T3", 48'(wr_addr), 48'hE17);
    checkOutput("t2_wr_en_T3", 48'(wr_en), 48'd1);
    step();
    wr_stall = 1'b0;
    checkOutput("t2_addr_T4", 48'(wr_addr), 48'hE17);
    step();
    checkOutput("t2_addr_T5", 48'(wr_addr), 48'hE18);
    checkOutput("t2_done_T5", 48'(done), 48'd0);
    step();
    checkOutput("t2_done_T6", 48'(done), 48'd1);
    checkOutput("t2_err_T6",  48'(err),  48'd0);
    step();

    // Two-row rectangle in the middle of the grid
    $display("[TB] 3x2 rectangle");
    applyStimulus(5, 2, 3, 2, 3);
    waitDone(50, cyc);
    checkOutput("t3_done_cycle", 48'(cyc), 48'd6);
    step();

    // Full screen: 300 writes, done at T+301, cmd_ready back at T+302
    $display("[TB] full screen");
    applyStimulus(0, 0, 20, 15, 7);
    waitDone(400, cyc);
    checkOutput("full_done_cycle", 48'(cyc), 48'd300);
    checkOutput("full_err", 48'(err), 48'd0);
    checkOutput("full_sb_drained", 48'(sbQ.size()), 48'd0);
    step();
    checkOutput("full_ready_T302", 48'(cmd_ready), 48'd1);

    // Rectangle off the bottom-right corner
    $display("[TB] corner overflow");
    applyStimulus(19, 14, 2, 2, 5);
`ifdef TILE_CLIP_EN
    checkOutput("corner_wr_en_T1", 48'(wr_en),   48'd1);
    checkOutput("corner_addr_T1",  48'(wr_addr), 48'hF2B);
    step();
    checkOutput("corner_done_T2",  48'(done),    48'd1);
    checkOutput("corner_err_T2",   48'(err),     48'd0);
`else
    checkOutput("corner_wr_en_T1", 48'(wr_en),   48'd0);
    checkOutput("corner_done_T1",  48'(done),    48'd1);
    checkOutput("corner_err_T1",   48'(err),     48'd1);
`endif
    step();
    checkOutput("corner_done_clr", 48'(done), 48'd0);
    checkOutput("corner_err_clr",  48'(err),  48'd0);
    step();

    // Zero-width command
    $display("[TB] empty command");
    applyStimulus(3, 3, 0, 2, 1);
    checkOutput("empty_wr_en_T1", 48'(wr_en), 48'd0);
    checkOutput("empty_done_T1",  48'(done),  48'd1);
    checkOutput("empty_err_T1",   48'(err),   48'd0);
    step();
    checkOutput("empty_ready_T2", 48'(cmd_ready), 48'd1);

    // Reset in the middle of a full-screen fill
    $display("[TB] reset mid-fill");
    applyStimulus(0, 0, 20, 15, 6);
    step();
    step();
    step();
    step();
    checkOutput("mid_wr_en_T5", 48'(wr_en), 48'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_wr_en", 48'(wr_en),     48'd0);
    checkOutput("mid_rst_busy",  48'(busy),      48'd0);
    checkOutput("mid_rst_ready", 48'(cmd_ready), 48'd0);
    checkOutput("mid_rst_addr",  48'(wr_addr),   48'hE00);
    sbQ.delete();
    step();
    reset = 1'b0;
    #1;
    checkOutput("mid_rel_ready", 48'(cmd_ready), 48'd1);
    checkOutput("mid_rel_done",  48'(done),      48'd0);
    applyStimulus(7, 3, 1, 1, 5);
    checkOutput("after_rst_wr_en", 48'(wr_en),   48'd1);
    checkOutput("after_rst_addr",  48'(wr_addr), 48'hE43);
    step();
    checkOutput("after_rst_done",  48'(done),    48'd1);
    checkOutput("after_rst_err",   48'(err),     48'd0);
    step();
    checkOutput("final_sb_drained", 48'(sbQ.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
